// File: rtl/led_pattern_ctrl.sv
// Switch-to-LED path: two-flop synchroniser, optional per-channel debouncer
// (LED_DEBOUNCE_EN), then direct / blink / PWM / chase display modes.
module led_pattern_ctrl #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned BLINK_DIV  = 8,
    parameter int unsigned PWM_BITS   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     sw,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic [N_CH-1:0]     led
);

    localparam int unsigned PreW = $clog2(BLINK_DIV);
    localparam logic [PreW-1:0] PreMax = PreW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ModeDirect = 2'b00,
        ModeBlink  = 2'b01,
        ModePwm    = 2'b10,
        ModeChase  = 2'b11
    } mode_e;

    logic [N_CH-1:0]     s1_q, s2_q;
    logic [N_CH-1:0]     sw_db;
    logic [PreW-1:0]     pre_q, pre_d;
    logic                blink_q, blink_d;
    logic [N_CH-1:0]     pos_q, pos_d, pos_rot;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [N_CH-1:0]     led_q, led_d;
    logic                tick;
    logic                pwm_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw;
            s2_q <= s1_q;
        end
    end

`ifdef LED_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    logic [N_CH-1:0] db_q, db_d;
    logic [CntW-1:0] cnt_q [N_CH];
    logic [CntW-1:0] cnt_d [N_CH];

    // A channel flips only after DEB_CYCLES consecutive disagreeing samples;
    // any agreeing sample restarts the run.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_db = db_q;
`else
    // DEB_CYCLES has no effect without the debouncer.
    logic unused_deb_cfg;
    assign unused_deb_cfg = ^DEB_CYCLES;
    assign sw_db = s2_q;
`endif

    if (N_CH == 1) begin : g_pos_single
        assign pos_rot = pos_q;
    end else begin : g_pos_multi
        assign pos_rot = {pos_q[N_CH-2:0], pos_q[N_CH-1]};
    end

    assign tick   = (pre_q == PreMax);
    assign pwm_on = (pwm_q < duty);

    always_comb begin
        pre_d   = tick ? '0 : pre_q + PreW'(1);
        blink_d = tick ? ~blink_q : blink_q;
        pos_d   = tick ? pos_rot : pos_q;
        pwm_d   = pwm_q + PWM_BITS'(1);
        led_d   = '0;
        unique case (mode_e'(mode))
            ModeDirect: led_d = sw_db;
            ModeBlink:  led_d = sw_db & {N_CH{blink_q}};
            ModePwm:    led_d = sw_db & {N_CH{pwm_on}};
            ModeChase:  led_d = sw_db & pos_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            blink_q <= 1'b0;
            pos_q   <= N_CH'(1);
            pwm_q   <= '0;
            led_q   <= '0;
        end else begin
            pre_q   <= pre_d;
            blink_q <= blink_d;
            pos_q   <= pos_d;
            pwm_q   <= pwm_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Randomised and directed bench for led_pattern_ctrl against a behavioural model
// that derives every LED value from the edge count since reset.
module tb_led_pattern_ctrl;

    localparam int unsigned N_CH       = 4;
    localparam int unsigned DEB_CYCLES = 16;
    localparam int unsigned BLINK_DIV  = 8;
    localparam int unsigned PWM_BITS   = 4;
`ifdef LED_DEBOUNCE_EN
    localparam int unsigned LAT = DEB_CYCLES + 3;
`else
    localparam int unsigned LAT = 3;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw    = 4'h0;
    logic [1:0] mode  = 2'b00;
    logic [3:0] duty  = 4'h0;
    logic [3:0] led;

    int checks = 0;
    int errors = 0;

    led_pattern_ctrl #(
        .N_CH       (N_CH),
        .DEB_CYCLES (DEB_CYCLES),
        .BLINK_DIV  (BLINK_DIV),
        .PWM_BITS   (PWM_BITS)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .mode  (mode),
        .duty  (duty),
        .led   (led)
    );

    always #5 clk = ~clk;

    // Model: k_m counts edges since reset release; timebases are k_m arithmetic.
    int unsigned k_m;
    logic [3:0]  d1_m, d2_m, db_m, led_m, src_m, pos_m;
    logic [3:0]  hist_m[$];
    bit          ph_m, pwm_m, flip_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_m   = 0;
            d1_m  = 4'h0;
            d2_m  = 4'h0;
            db_m  = 4'h0;
            led_m = 4'h0;
            hist_m.delete();
        end else begin
`ifdef LED_DEBOUNCE_EN
            src_m = db_m;
`else
            src_m = d2_m;
`endif
            ph_m  = ((k_m / BLINK_DIV) % 2) == 1;
            pos_m = 4'b0001 << ((k_m / BLINK_DIV) % N_CH);
            pwm_m = (k_m % (1 << PWM_BITS)) < duty;
            case (mode)
                2'b00:   led_m = src_m;
                2'b01:   led_m = ph_m ? src_m : 4'h0;
                2'b10:   led_m = pwm_m ? src_m : 4'h0;
                default: led_m = src_m & pos_m;
            endcase
            // Accept a channel once the last DEB_CYCLES synchronised samples all disagree.
            hist_m.push_back(d2_m);
            if (hist_m.size() > DEB_CYCLES) void'(hist_m.pop_front());
            if (hist_m.size() == DEB_CYCLES) begin
                for (int i = 0; i < 4; i++) begin
                    flip_m = 1'b1;
                    foreach (hist_m[j]) if (hist_m[j][i] == db_m[i]) flip_m = 1'b0;
                    if (flip_m) db_m[i] = ~db_m[i];
                end
            end
            d2_m = d1_m;
            d1_m = sw;
            k_m++;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (led !== led_m) begin
            errors++;
            $display("FAIL model_cmp t=%0t mode=%b led=%b expected %b", $time, mode, led, led_m);
        end
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t led=%b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Asserts reset mid-cycle, checks the immediate clear, releases mid-cycle.
    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("reset_led", led, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic run_to(input int unsigned e);
        while (k_m < e) begin
            @(posedge clk);
            #2;
        end
    endtask

    int found;
    int n_on;
    int unsigned len;

    initial begin
        // Reset and direct-mode latency.
        sw = 4'hF; mode = 2'b00; duty = 4'h0;
        do_reset();
        for (int e = 1; e <= int'(LAT); e++) begin
            @(posedge clk);
            #2;
            if (e < int'(LAT)) check("latency_pre", led, 4'h0);
            else check("latency_edge", led, 4'hF);
        end

        // Bounce on sw[0], then a stable 1.
        sw = 4'h0;
        do_reset();
        run_to(LAT + 4);
        for (int c = 0; c < 42; c++) begin
            sw[0] = ((c / 3) % 2) == 0;
            @(posedge clk);
            #2;
`ifdef LED_DEBOUNCE_EN
            check("bounce_hold_low", {3'b000, led[0]}, 4'h0);
`endif
        end
        sw[0] = 1'b1;
        found = 0;
        for (int n = 1; n <= 60 && found == 0; n++) begin
            @(posedge clk);
            #2;
            if (led[0]) found = n;
        end
        check_int("bounce_rise_edge", found, int'(LAT));

        // Blink.
        sw = 4'b0101; mode = 2'b01;
        do_reset();
        run_to(20); check("blink_e20", led, 4'b0000);
        run_to(25); check("blink_e25", led, 4'b0101);
        run_to(33); check("blink_e33", led, 4'b0000);
        run_to(41); check("blink_e41", led, 4'b0101);

        // PWM duty 4, 0, 15 over whole 16-edge periods.
        sw = 4'hF; mode = 2'b10; duty = 4'd4;
        do_reset();
        run_to(19);
        n_on = 0;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk); #2; if (led == 4'hF) n_on++;
        end
        check_int("pwm_duty4", n_on, 4);
        duty = 4'd0;
        n_on = 0;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk); #2; if (led != 4'h0) n_on++;
        end
        check_int("pwm_duty0", n_on, 0);
        duty = 4'd15;
        n_on = 0;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk); #2; if (led == 4'hF) n_on++;
        end
        check_int("pwm_duty15", n_on, 15);

        // Chase and wrap.
        mode = 2'b11; sw = 4'hF;
        do_reset();
        run_to(20); check("chase_e20", led, 4'b0100);
        run_to(25); check("chase_e25", led, 4'b1000);
        run_to(33); check("chase_e33", led, 4'b0001);
        run_to(41); check("chase_e41", led, 4'b0010);
        sw = 4'b1011;
        do_reset();
        run_to(20); check("chase_masked_e20", led, 4'b0000);
        run_to(25); check("chase_masked_e25", led, 4'b1000);

        // Async reset while the chase shows 1000, then restart.
        sw = 4'hF;
        do_reset();
        run_to(26);
        check("chase_pre_reset", led, 4'b1000);
        #1 rst_n = 1'b0;
        #1 check("async_reset_clear", led, 4'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_to(20); check("restart_e20", led, 4'b0100);
        run_to(33); check("restart_e33", led, 4'b0001);

        // Randomised segments.
        for (int s = 0; s < 45; s++) begin
            mode = 2'($urandom_range(0, 3));
            duty = 4'($urandom);
            if ($urandom_range(0, 9) == 0) do_reset();
            sw  = 4'($urandom);
            len = $urandom_range(5, 60);
            for (int c = 0; c < int'(len); c++) begin
                if ($urandom_range(0, 7) == 0) sw = sw ^ 4'($urandom);
                @(posedge clk);
                #2;
            end
        end

        @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t bench did not complete", $time);
        $fatal(1, "watchdog");
    end

endmodule
